// File: rtl/load_store_unit.sv
// Load/store initiator between the MEM stage and a word-ported data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRead,
  output logic              memWrite,
  output logic [31:0]       writeData,
  input  logic [31:0]       readData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsuState_t;

  localparam logic [1:0]        SIZE_BYTE = 2'b00;
  localparam logic [1:0]        SIZE_HALF = 2'b01;
  localparam logic [1:0]        SIZE_WORD = 2'b10;
  localparam logic [1:0]        SIZE_ILL  = 2'b11;
  localparam logic [ADDR_W-1:0] LANE_BITS = ADDR_W'(3);

  lsuState_t         state;
  lsuState_t         nextState;

  logic              reqWe;
  logic [1:0]        reqSize;
  logic              reqUnsigned;
  logic [ADDR_W-1:0] reqAddr;
  logic [15:0]       reqWdata;
  logic              reqErr;
  logic [31:0]       holdWord;

  logic              accept;
  logic              misaligned;
  logic [ADDR_W-1:0] activeWordAddr;
  logic [4:0]        laneShift;
  logic [31:0]       laneMask;
  logic [31:0]       laneData;
  logic [31:0]       mergedWord;
  logic [31:0]       nextWriteData;
  logic [31:0]       laneShifted;
  logic [31:0]       loadResult;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign misaligned = ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_size == SIZE_ILL);

  // In IDLE the address comes straight from the request so the first access
  // can be launched on the acceptance edge; afterwards it comes from the copy.
  assign activeWordAddr = (state == IDLE) ? (req_addr & ~LANE_BITS)
                                          : (reqAddr & ~LANE_BITS);
  assign laneShift      = {reqAddr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            nextState = RESP;
          end else if (req_we && (req_size == SIZE_WORD)) begin
            nextState = WR;
          end else begin
            nextState = RD;
          end
        end
      end
      RD:      nextState = reqWe ? WR : RESP;
      WR:      nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reqWe       <= 1'b0;
      reqSize     <= 2'b00;
      reqUnsigned <= 1'b0;
      reqAddr     <= '0;
      reqWdata    <= 16'h0;
      reqErr      <= 1'b0;
    end else if (accept) begin
      reqWe       <= req_we;
      reqSize     <= req_size;
      reqUnsigned <= req_unsigned;
      reqAddr     <= req_addr;
      reqWdata    <= req_wdata[15:0];
      reqErr      <= misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdWord <= 32'h0;
    end else if (state == RD) begin
      holdWord <= readData;
    end
  end

  // Merge happens while the RD access is live, so the write word can be
  // registered on the same edge that captures the read word.
  always_comb begin
    laneMask = 32'h0;
    laneData = 32'h0;
    if (reqSize == SIZE_BYTE) begin
      laneMask = 32'h0000_00FF << laneShift;
      laneData = {4{reqWdata[7:0]}};
    end else begin
      laneMask = 32'h0000_FFFF << laneShift;
      laneData = {2{reqWdata}};
    end
    mergedWord = (readData & ~laneMask) | (laneData & laneMask);
  end

  assign nextWriteData = (state == IDLE) ? req_wdata : mergedWord;

  always_ff @(posedge clk) begin
    if (rst) begin
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      writeData <= 32'h0;
    end else begin
      memRead   <= (nextState == RD);
      memWrite  <= (nextState == WR);
      memAddr   <= ((nextState == RD) || (nextState == WR)) ? activeWordAddr : '0;
      writeData <= (nextState == WR) ? nextWriteData : 32'h0;
    end
  end

  always_comb begin
    laneShifted = holdWord >> laneShift;
    loadResult  = holdWord;
    case (reqSize)
      SIZE_BYTE: loadResult = reqUnsigned ? {24'h0, laneShifted[7:0]}
                                          : {{24{laneShifted[7]}}, laneShifted[7:0]};
      SIZE_HALF: loadResult = reqUnsigned ? {16'h0, laneShifted[15:0]}
                                          : {{16{laneShifted[15]}}, laneShifted[15:0]};
      default:   loadResult = holdWord;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && reqErr;
  assign resp_rdata = (resp_valid && !reqErr && !reqWe) ? loadResult : 32'h0;

endmodule
